// File: rtl/encoder_transmitter.sv
// Streams rows of solver RAM to the CPU as run-length packets in 32-bit words.
// The words are a packet-size header, a row-count header, then packed packets, all over valid/ack.
module encoder_transmitter #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int PACKET_SIZE   = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Sending_Enable,
  input  logic [ADDRESS_WIDTH-1:0] Start_Address,
  input  logic [ADDRESS_WIDTH-1:0] Row_Stride,
  input  logic [15:0]              Rows_Num,
  input  logic [11:0]              Row_Elements,
  output logic                     RAM_Read,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  input  logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic [31:0]              CPU_Bus,
  output logic                     Word_Valid,
  input  logic                     CPU_Ack,
  output logic                     Done_Sending
);

  localparam int unsigned SLOTS = 32 / PACKET_SIZE;
  localparam int          RUN_W = PACKET_SIZE - 1;
  localparam int          BIT_W = $clog2(DATA_WIDTH);
  localparam int          SC_W  = $clog2(SLOTS + 1);
  localparam logic [RUN_W-1:0] MAX_RUN = '1;

  typedef enum logic [2:0] {
    IDLE, HDR_SIZE, HDR_ROWS, FETCH, WAIT_DATA, ENCODE, FLUSH, DONE
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] stride_q, row_base;
  logic [15:0]              rows_q, row_cnt;
  logic [11:0]              elems_q, elem_cnt;
  logic [BIT_W-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0]    shreg;
  logic                     cur_val, ind, tail;
  logic [RUN_W-1:0]         run_len;
  logic [31:0]              asm_buf;
  logic [SC_W-1:0]          asm_cnt;

  logic                     acc, busy, bit_in, next_val, word_rdy;
  logic [1:0]               n_pkt;
  logic [PACKET_SIZE-1:0]   pk0, pk1;
  logic [RUN_W-1:0]         next_run;
  logic [31:0]              asm_buf_n, word_out, pad_word;
  logic [SC_W-1:0]          asm_cnt_n;

  assign acc    = Word_Valid && CPU_Ack;
  assign busy   = Word_Valid && !CPU_Ack;
  assign bit_in = shreg[DATA_WIDTH-1];

  // Overflow emits MAX_RUN plus an empty opposite-value packet in the same cycle.
  always_comb begin
    pk0      = {ind, run_len};
    pk1      = {ind, {RUN_W{1'b0}}};
    n_pkt    = 2'd0;
    next_val = cur_val;
    next_run = run_len;
    if (tail) begin
      n_pkt = 2'd1;
    end else if (bit_in != cur_val) begin
      n_pkt    = 2'd1;
      next_val = bit_in;
      next_run = RUN_W'(1);
    end else if (run_len == MAX_RUN) begin
      n_pkt    = 2'd2;
      next_run = RUN_W'(1);
    end else begin
      next_run = run_len + 1'b1;
    end
  end

  always_comb begin
    asm_buf_n = asm_buf;
    asm_cnt_n = asm_cnt;
    word_rdy  = 1'b0;
    word_out  = asm_buf;
    for (int unsigned i = 0; i < 2; i++) begin
      if (2'(i) < n_pkt) begin
        asm_buf_n = {asm_buf_n[31-PACKET_SIZE:0], (i == 0) ? pk0 : pk1};
        asm_cnt_n = asm_cnt_n + 1'b1;
        if (asm_cnt_n == SC_W'(SLOTS)) begin
          word_rdy  = 1'b1;
          word_out  = asm_buf_n;
          asm_buf_n = '0;
          asm_cnt_n = '0;
        end
      end
    end
  end

  always_comb begin
    pad_word = asm_buf;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (SC_W'(i) >= asm_cnt)
        pad_word = {pad_word[31-PACKET_SIZE:0], ind, {RUN_W{1'b0}}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      RAM_Read     <= 1'b0;
      RAM_Address  <= '0;
      CPU_Bus      <= '0;
      Word_Valid   <= 1'b0;
      Done_Sending <= 1'b0;
      stride_q     <= '0;
      row_base     <= '0;
      rows_q       <= '0;
      row_cnt      <= '0;
      elems_q      <= '0;
      elem_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      cur_val      <= 1'b0;
      ind          <= 1'b0;
      tail         <= 1'b0;
      run_len      <= '0;
      asm_buf      <= '0;
      asm_cnt      <= '0;
    end else begin
      if (acc) Word_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Sending_Enable) begin
            Done_Sending <= 1'b0;
            stride_q     <= Row_Stride;
            rows_q       <= Rows_Num;
            elems_q      <= Row_Elements;
            row_base     <= Start_Address;
            row_cnt      <= '0;
            elem_cnt     <= '0;
            cur_val      <= 1'b0;
            run_len      <= '0;
            ind          <= 1'b0;
            tail         <= 1'b0;
            asm_buf      <= '0;
            asm_cnt      <= '0;
            state        <= HDR_SIZE;
          end
        end
        HDR_SIZE: begin
          if (!Word_Valid) begin
            CPU_Bus    <= {26'b0, 6'(PACKET_SIZE)};
            Word_Valid <= 1'b1;
          end else if (acc) begin
            CPU_Bus    <= {16'b0, rows_q};
            Word_Valid <= 1'b1;
            state      <= HDR_ROWS;
          end
        end
        HDR_ROWS: begin
          if (acc) begin
            if (rows_q == 16'd0) begin
              state <= DONE;
            end else begin
              RAM_Read    <= 1'b1;
              RAM_Address <= row_base;
              state       <= FETCH;
            end
          end
        end
        FETCH: begin
          // Entry may hold off the strobe while a full word waits for the CPU.
          if (RAM_Read) begin
            RAM_Read <= 1'b0;
            state    <= WAIT_DATA;
          end else if (!busy) begin
            RAM_Read <= 1'b1;
          end
        end
        WAIT_DATA: begin
          shreg   <= RAM_Data;
          bit_idx <= '0;
          state   <= ENCODE;
        end
        ENCODE: begin
          if (!busy) begin
            asm_buf <= asm_buf_n;
            asm_cnt <= asm_cnt_n;
            if (word_rdy) begin
              CPU_Bus    <= word_out;
              Word_Valid <= 1'b1;
            end
            if (tail) begin
              tail     <= 1'b0;
              ind      <= ~ind;
              row_cnt  <= row_cnt + 16'd1;
              elem_cnt <= '0;
              cur_val  <= 1'b0;
              run_len  <= '0;
              if (row_cnt + 16'd1 == rows_q) begin
                state <= FLUSH;
              end else begin
                row_base    <= row_base + stride_q;
                RAM_Address <= row_base + stride_q;
                RAM_Read    <= !word_rdy;
                state       <= FETCH;
              end
            end else begin
              shreg   <= shreg << 1;
              cur_val <= next_val;
              run_len <= next_run;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                if (elem_cnt + 12'd1 == elems_q) begin
                  tail <= 1'b1;
                end else begin
                  elem_cnt    <= elem_cnt + 12'd1;
                  RAM_Address <= RAM_Address + 1'b1;
                  RAM_Read    <= !word_rdy;
                  state       <= FETCH;
                end
              end
            end
          end
        end
        FLUSH: begin
          if (!busy) begin
            if (asm_cnt != '0) begin
              CPU_Bus    <= pad_word;
              Word_Valid <= 1'b1;
              asm_buf    <= '0;
              asm_cnt    <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          Done_Sending <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/encoder_transmitter.md
# encoder_transmitter

Reads rows of DATA_WIDTH-bit elements from the solver RAM (solution vectors, results), run-length encodes each row bit-serially, and streams the code to the CPU as 32-bit words over a valid/acknowledge handshake. It is the transmit-side counterpart of the loading path, producing exactly the word format the loader consumes: a packet-size word, a row-count word, then packed run-length packets.

## Interface
- ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, element width
- PACKET_SIZE, 8, bits per packet; legal values 2, 4, 8, 16 (must divide 32)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- Sending_Enable  in  1  start request; sampled only in IDLE
- Start_Address  in  ADDRESS_WIDTH  address of row 0, element 0
- Row_Stride  in  ADDRESS_WIDTH  address distance between first elements of consecutive rows
- Rows_Num  in  16  rows to send (0 legal)
- Row_Elements  in  12  elements per row (≥1)
- RAM_Read  out  1  read strobe
- RAM_Address  out  ADDRESS_WIDTH  read address
- RAM_Data  in  DATA_WIDTH  read data, valid the cycle after RAM_Read
- CPU_Bus  out  32  word to CPU
- Word_Valid  out  1  CPU_Bus holds a word
- CPU_Ack  in  1  CPU accepts word; transfer when Word_Valid && CPU_Ack
- Done_Sending  out  1  high from completion until next start

Configuration inputs are latched on start and ignored afterwards.

## Operation
- Packet format: MSB = indication bit, low PACKET_SIZE-1 bits = run length L (0..MAX_RUN, MAX_RUN = 2^(PACKET_SIZE-1)-1). Packets fill a word from bit 31 downward; 32/PACKET_SIZE packets per word.
- Indication bit is constant within a row and toggles per row; row 0 uses 0. The receiver detects row end by the toggle.
- Runs alternate bit value; the first run of every row encodes value 0 (L=0 if the row starts with 1). Elements of a row are concatenated MSB first, element 0 first; runs cross element boundaries.
- Run longer than MAX_RUN: emit MAX_RUN, then a L=0 packet of the opposite value, then continue counting.
- Row end: emit the pending run (may be the only packet). Next row starts in the same word.
- After the last row: fill remaining slots of the current word with L=0 packets carrying the toggled indication bit; if the word is already empty nothing extra is sent. Rows_Num=0: send only the two header words.
- Header words: word 0 = {26'b0, PACKET_SIZE[5:0]}, word 1 = {16'b0, Rows_Num}.
- FSM: IDLE → HDR_SIZE → HDR_ROWS → FETCH → WAIT_DATA → ENCODE → (FETCH next element | FETCH next row | FLUSH) → DONE → IDLE.
  - IDLE: Sending_Enable=1 latches config, clears Done_Sending.
  - HDR_SIZE/HDR_ROWS: present header, advance on acceptance.
  - FETCH: RAM_Read=1 one cycle; WAIT_DATA captures RAM_Data into a shift register.
  - ENCODE: one bit per cycle; same value increments run counter, change emits packet. Packet emission inserts into the word assembler; when the word fills it is presented and ENCODE stalls until accepted.
  - FLUSH: pad and send final partial word. DONE: Done_Sending=1, return to IDLE.
- Addressing: element e of row r at Start_Address + r·Row_Stride + e, modulo 2^ADDRESS_WIDTH (wraps silently).
- Counters: rows 16 bit, elements 12 bit, bit index log2(DATA_WIDTH) bits, run PACKET_SIZE-1 bits saturating at MAX_RUN.

## Timing
- Reset values: RAM_Read=0, RAM_Address=0, CPU_Bus=0, Word_Valid=0, Done_Sending=0, state IDLE. RST mid-operation aborts immediately; no partial word is ever sent; Word_Valid drops the cycle after RST is sampled.
- Start latency: Sending_Enable sampled high at edge n → Word_Valid=1 with header word 0 after edge n+1.
- Word_Valid, once high, stays high with CPU_Bus stable until accepted; deasserts the cycle after acceptance unless the next word is ready, in which case back-to-back words are allowed.
- CPU_Ack without Word_Valid is ignored.
- Per element: 2 cycles fetch + DATA_WIDTH encode cycles, plus stall cycles.
- Done_Sending rises the cycle after the final word is accepted; stays high until next start or RST.

## Test plan
- PACKET_SIZE=8, Rows_Num=0, CPU_Ack tied 1 → exactly two words 0x00000008, 0x00000000, then Done_Sending=1.
- 1 row, 1 element 0xFFFFFFFF00000000 → headers, then word 0x00_20_20_80 (L0 zeros, 32 ones, 32 zeros, pad indication 1 L0).
- 1 row, element all zeros → run 64 > MAX_RUN(127)? no: packets 0x40, pad 0x80 ×3 → word 0x40808080.
- PACKET_SIZE=4 (MAX_RUN 7), element 0x0000_0000_0000_0000 → runs 7,0 alternating to total 64, last word padded with 0x8 nibbles; receiver-side decode reproduces zeros.
- 2 rows × 2 elements, Row_Stride=50, Start_Address=5007 → reads 5007, 5008, 5057, 5058; row 1 packets carry indication 1.
- CPU_Ack held low 10 cycles on word 3 → CPU_Bus stable, no RAM_Read during stall; RST asserted mid-stall → all outputs at reset values next cycle.
